// File: rtl/sigdelay_prog.sv
// Programmable circular-buffer delay line with offset reload, warm-up silencing and output strobe.
// Optional echo feedback into the buffer is enabled by defining ECHO_FEEDBACK_EN.
module sigdelay_prog #(
    parameter int unsigned         A_WIDTH  = 9,
    parameter int unsigned         D_WIDTH  = 8,
    parameter logic [D_WIDTH-1:0]  SILENCE  = '0,
    parameter int unsigned         FB_SHIFT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [D_WIDTH-1:0] mic_signal,
    input  logic [A_WIDTH-1:0] offset,
    input  logic               offset_load,
    output logic [D_WIDTH-1:0] delayed_signal,
    output logic               out_valid,
    output logic               warming
);

    localparam int unsigned DEPTH = 1 << A_WIDTH;

    typedef enum logic {
        RUN  = 1'b0,
        FILL = 1'b1
    } state_t;

    if (FB_SHIFT > D_WIDTH) begin : g_bad_fb_shift
        $error("FB_SHIFT exceeds D_WIDTH");
    end

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [A_WIDTH-1:0] wr_ptr;
    logic [A_WIDTH-1:0] hist_cnt;
    logic [A_WIDTH-1:0] active_offset;
    state_t             state;

    logic [A_WIDTH-1:0] eff_offset_c;
    logic [A_WIDTH-1:0] rd_addr_c;
    logic [D_WIDTH-1:0] rd_word_c;
    logic [D_WIDTH-1:0] wdata_c;
    logic               fill_c;
`ifdef ECHO_FEEDBACK_EN
    logic [D_WIDTH-1:0] fb_c;
    logic [D_WIDTH:0]   sum_c;
`endif

    // A same-cycle reload takes effect for the sample accepted in that cycle.
    always_comb begin
        eff_offset_c = offset_load ? offset : active_offset;
        fill_c       = (eff_offset_c > hist_cnt);
        rd_addr_c    = wr_ptr - eff_offset_c;
        rd_word_c    = (eff_offset_c == '0) ? mic_signal : mem[rd_addr_c];
`ifdef ECHO_FEEDBACK_EN
        fb_c    = (!fill_c && (eff_offset_c != '0)) ? rd_word_c : '0;
        sum_c   = (D_WIDTH+1)'(mic_signal) + (D_WIDTH+1)'(fb_c >> FB_SHIFT);
        wdata_c = sum_c[D_WIDTH] ? '1 : sum_c[D_WIDTH-1:0];
`else
        wdata_c = mic_signal;
`endif
    end

    // Sample storage; intentionally not reset, warm-up hides stale contents.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[wr_ptr] <= wdata_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr         <= '0;
            hist_cnt       <= '0;
            active_offset  <= '0;
            state          <= RUN;
            delayed_signal <= '0;
            out_valid      <= 1'b0;
        end else begin
            if (offset_load) begin
                active_offset <= offset;
            end
            state     <= fill_c ? FILL : RUN;
            out_valid <= en;
            if (en) begin
                wr_ptr         <= wr_ptr + A_WIDTH'(1);
                delayed_signal <= fill_c ? SILENCE : rd_word_c;
                if (hist_cnt != A_WIDTH'(DEPTH - 1)) begin
                    hist_cnt <= hist_cnt + A_WIDTH'(1);
                end
            end
        end
    end

    assign warming = (state == FILL);

endmodule

// File: tb/tb_sigdelay_prog.sv
// Directed self-checking bench for sigdelay_prog: default depth plus an 8-deep instance for wrap checks.
module tb_sigdelay_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       offset_load = 1'b0;
    logic [7:0] mic_signal = '0;
    logic [8:0] offset = '0;
    logic [2:0] offset8;
    logic [7:0] delayed_signal;
    logic       out_valid;
    logic       warming;
    logic [7:0] d8_delayed;
    logic       d8_valid;
    logic       d8_warming;

    int checks = 0;
    int passed = 0;

    assign offset8 = offset[2:0];

    always #5 clk = ~clk;

    sigdelay_prog u_dut (
        .clk(clk), .rst(rst), .en(en), .mic_signal(mic_signal), .offset(offset),
        .offset_load(offset_load), .delayed_signal(delayed_signal),
        .out_valid(out_valid), .warming(warming)
    );

    sigdelay_prog #(.A_WIDTH(3)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .mic_signal(mic_signal), .offset(offset8),
        .offset_load(offset_load), .delayed_signal(d8_delayed),
        .out_valid(d8_valid), .warming(d8_warming)
    );

    task automatic tick(input logic e, input logic [7:0] d);
        en = e;
        mic_signal = d;
        @(posedge clk);
        #1;
        en = 1'b0;
        offset_load = 1'b0;
    endtask

    task automatic load(input logic [8:0] o);
        offset = o;
        offset_load = 1'b1;
        tick(1'b0, 8'd0);
    endtask

    task automatic do_reset;
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (delayed_signal !== 8'd0) $display("FAIL reset_delayed: got %0h expected 0", delayed_signal); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", out_valid); else passed++;
        checks++; if (warming !== 1'b0) $display("FAIL reset_warming: got %0b expected 0", warming); else passed++;
    endtask

    task automatic test_warmup;
        logic [7:0] exp;
        do_reset();
        load(9'd4);
        checks++; if (warming !== 1'b1) $display("FAIL warm_after_load: got %0b expected 1", warming); else passed++;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1, 8'(i));
            exp = (i <= 4) ? 8'd0 : 8'(i - 4);
            checks++; if (delayed_signal !== exp) $display("FAIL warm_data[%0d]: got %0d expected %0d", i, delayed_signal, exp); else passed++;
            checks++; if (warming !== (i <= 4)) $display("FAIL warm_flag[%0d]: got %0b expected %0b", i, warming, (i <= 4)); else passed++;
            checks++; if (out_valid !== 1'b1) $display("FAIL warm_valid[%0d]: got %0b expected 1", i, out_valid); else passed++;
        end
        tick(1'b0, 8'd99);
        checks++; if (out_valid !== 1'b0) $display("FAIL warm_idle_valid: got %0b expected 0", out_valid); else passed++;
        checks++; if (delayed_signal !== 8'd8) $display("FAIL warm_idle_hold: got %0d expected 8", delayed_signal); else passed++;
    endtask

    task automatic test_offset_zero;
        do_reset();
        load(9'd0);
        checks++; if (warming !== 1'b0) $display("FAIL zero_warm_load: got %0b expected 0", warming); else passed++;
        tick(1'b1, 8'hA5);
        checks++; if (delayed_signal !== 8'hA5) $display("FAIL zero_a5: got %0h expected a5", delayed_signal); else passed++;
        checks++; if (warming !== 1'b0) $display("FAIL zero_warm_1: got %0b expected 0", warming); else passed++;
        tick(1'b1, 8'h3C);
        checks++; if (delayed_signal !== 8'h3C) $display("FAIL zero_3c: got %0h expected 3c", delayed_signal); else passed++;
        checks++; if (warming !== 1'b0) $display("FAIL zero_warm_2: got %0b expected 0", warming); else passed++;
    endtask

    task automatic test_wrap;
        logic [7:0] exp;
        do_reset();
        load(9'd7);
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 8'(i));
            exp = (i <= 7) ? 8'd0 : 8'(i - 7);
            checks++; if (d8_delayed !== exp) $display("FAIL wrap8_data[%0d]: got %0d expected %0d", i, d8_delayed, exp); else passed++;
            checks++; if (delayed_signal !== exp) $display("FAIL wrap512_data[%0d]: got %0d expected %0d", i, delayed_signal, exp); else passed++;
        end
    endtask

    task automatic test_reload;
        logic [7:0] exp;
        do_reset();
        load(9'd5);
        for (int i = 1; i <= 10; i++) tick(1'b1, 8'(i + 10));
        offset = 9'd2;
        offset_load = 1'b1;
        tick(1'b1, 8'd21);
        checks++; if (delayed_signal !== 8'd19) $display("FAIL reload_down: got %0d expected 19", delayed_signal); else passed++;
        checks++; if (warming !== 1'b0) $display("FAIL reload_down_warm: got %0b expected 0", warming); else passed++;
        load(9'd7);
        checks++; if (warming !== 1'b0) $display("FAIL reload_up_warm: got %0b expected 0", warming); else passed++;
        tick(1'b1, 8'd22);
        checks++; if (delayed_signal !== 8'd15) $display("FAIL reload_up_data: got %0d expected 15", delayed_signal); else passed++;
        do_reset();
        load(9'd7);
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 8'(i + 40));
            exp = (i <= 7) ? 8'd0 : 8'd41;
            checks++; if (warming !== (i <= 7)) $display("FAIL rerst_warm[%0d]: got %0b expected %0b", i, warming, (i <= 7)); else passed++;
            checks++; if (delayed_signal !== exp) $display("FAIL rerst_data[%0d]: got %0d expected %0d", i, delayed_signal, exp); else passed++;
        end
    endtask

    task automatic test_gapped;
        logic [7:0] exp;
        do_reset();
        load(9'd1);
        for (int k = 0; k < 6; k++) begin
            exp = (k == 0) ? 8'd0 : 8'(50 + k - 1);
            tick(1'b1, 8'(50 + k));
            checks++; if (out_valid !== 1'b1) $display("FAIL gap_pulse[%0d]: got %0b expected 1", k, out_valid); else passed++;
            checks++; if (delayed_signal !== exp) $display("FAIL gap_data[%0d]: got %0d expected %0d", k, delayed_signal, exp); else passed++;
            for (int j = 0; j < 2; j++) begin
                tick(1'b0, 8'hFF);
                checks++; if (out_valid !== 1'b0) $display("FAIL gap_idle_valid[%0d]: got %0b expected 0", k, out_valid); else passed++;
                checks++; if (delayed_signal !== exp) $display("FAIL gap_hold[%0d]: got %0d expected %0d", k, delayed_signal, exp); else passed++;
            end
        end
        tick(1'b1, 8'd77);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (delayed_signal !== 8'd0) $display("FAIL async_rst_data: got %0d expected 0", delayed_signal); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL async_rst_valid: got %0b expected 0", out_valid); else passed++;
        checks++; if (warming !== 1'b0) $display("FAIL async_rst_warm: got %0b expected 0", warming); else passed++;
        #1;
        rst = 1'b1;
    endtask

`ifdef ECHO_FEEDBACK_EN
    task automatic test_echo;
        logic [7:0] din_a [7] = '{8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        logic [7:0] exp_a [7] = '{8'd0, 8'd0, 8'd200, 8'd0, 8'd100, 8'd0, 8'd50};
        logic [7:0] din_b [5] = '{8'd200, 8'd0, 8'd250, 8'd0, 8'd0};
        logic [7:0] exp_b [5] = '{8'd0, 8'd0, 8'd200, 8'd0, 8'd255};
        do_reset();
        load(9'd2);
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, din_a[i]);
            checks++; if (delayed_signal !== exp_a[i]) $display("FAIL echo_decay[%0d]: got %0d expected %0d", i, delayed_signal, exp_a[i]); else passed++;
        end
        do_reset();
        load(9'd2);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, din_b[i]);
            checks++; if (delayed_signal !== exp_b[i]) $display("FAIL echo_sat[%0d]: got %0d expected %0d", i, delayed_signal, exp_b[i]); else passed++;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_warmup();
        test_offset_zero();
        test_wrap();
        test_reload();
        test_gapped();
`ifdef ECHO_FEEDBACK_EN
        test_echo();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
